// File: rtl/filter_spad_ctrl.sv
// filter_spad_ctrl: initiator-side controller for the 224x16 filter scratchpad.
// Writes an incoming weight stream into the scratchpad over the shared
// tristate bus, and on command reads the filter back in address order as a
// valid/ready stream for the PE MAC, hiding the scratchpad's one-cycle
// registered read latency behind a small credit-managed skid buffer.
// Optional build macro: FILTER_SPAD_CTRL_REPEAT_EN adds rd_repeat/pass_last
// for back-to-back multi-pass readout (convolution row reuse).

module filter_spad_ctrl #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 224,
  parameter int BUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cfg_len,
  input  logic              ld_start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              rd_start,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
`ifdef FILTER_SPAD_CTRL_REPEAT_EN
  input  logic [7:0]        rd_repeat,
  output logic              pass_last,
`endif
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] spad_addr,
  output logic              spad_we,
  inout  wire  [DATA_W-1:0] spad_data
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W:0]  BUF_LIMIT = (CNT_W + 1)'(BUF_DEPTH);
  localparam logic [ADDR_W-1:0] LEN_MAX = ADDR_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, READ, DRAIN} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
`ifdef FILTER_SPAD_CTRL_REPEAT_EN
    logic              pass_last;
`endif
  } entry_t;

  state_t            state, state_nxt;

  // Command context
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] len_clip;
  logic              len_zero;
  logic              start_ld, start_rd;

  // Load path
  logic [ADDR_W-1:0] wcnt;
  logic [DATA_W-1:0] wr_data;
  logic              ld_accept, ld_last;

  // Read issue path
  logic [ADDR_W-1:0] rcnt;
  logic [ADDR_W-1:0] issue_addr, eff_len;
  logic              issue, pass_end, final_pass, issue_final;
  logic [CNT_W:0]    occupancy;
  logic              credit_ok;

  // Read-latency pipeline: stage 1 = address on the scratchpad port,
  // stage 2 = registered data on the bus, captured at the end of stage 2.
  logic              rd_v1, rd_v2;
  logic              last1, last2;
`ifdef FILTER_SPAD_CTRL_REPEAT_EN
  logic [7:0]        rep_q, pass_cnt;
  logic              pl1, pl2;
`endif

  // Skid buffer
  entry_t            buf_mem [BUF_DEPTH];
  entry_t            push_entry, head_entry;
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  buf_count;
  logic              push, pop;
  logic              drain_done;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Command decode and issue control
  // ---------------------------------------------------------------------------
  assign len_clip  = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
  assign len_zero  = (len_clip == '0);
  assign start_ld  = (state == IDLE) && ld_start;
  assign start_rd  = (state == IDLE) && rd_start && !ld_start;

  assign ld_accept = (state == LOAD) && ld_valid;
  assign ld_last   = ld_accept && (wcnt == len_q - ADDR_W'(1));

  // Buffered words plus reads still in the scratchpad pipeline may never
  // exceed the buffer size, so every issued read is guaranteed a slot.
  assign occupancy = {1'b0, buf_count} + (CNT_W + 1)'(rd_v1) + (CNT_W + 1)'(rd_v2);
  assign credit_ok = (occupancy < BUF_LIMIT);

  // The first read is issued on the accepting edge itself so the first word
  // reaches out_valid three cycles after rd_start.
  assign issue      = (start_rd && !len_zero) || ((state == READ) && credit_ok);
  assign issue_addr = (state == IDLE) ? '0 : rcnt;
  assign eff_len    = (state == IDLE) ? len_clip : len_q;
  assign pass_end   = issue && (issue_addr == eff_len - ADDR_W'(1));

`ifdef FILTER_SPAD_CTRL_REPEAT_EN
  assign final_pass = (state == IDLE) ? (rd_repeat == 8'd0) : (pass_cnt == rep_q);
`else
  assign final_pass = 1'b1;
`endif
  assign issue_final = pass_end && final_pass;

  assign drain_done = !spad_we && !rd_v1 && !rd_v2 && (buf_count == '0);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  // NOTE: state_nxt gets a default first so no path leaves it unassigned and
  // no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_ld && !len_zero)      state_nxt = LOAD;
        else if (start_rd && !len_zero) state_nxt = issue_final ? DRAIN : READ;
      end
      LOAD:    if (ld_last)     state_nxt = DRAIN;
      READ:    if (issue_final) state_nxt = DRAIN;
      DRAIN:   if (drain_done)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-derived outputs.
  always_comb begin
    busy     = (state != IDLE);
    ld_ready = (state == LOAD);
  end

  // ---------------------------------------------------------------------------
  // Datapath: counters, scratchpad port, read pipeline, done pulse
  // ---------------------------------------------------------------------------
  // Scratchpad sequencing and command bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q     <= '0;
      wcnt      <= '0;
      rcnt      <= '0;
      wr_data   <= '0;
      spad_we   <= 1'b0;
      spad_addr <= '0;
      done      <= 1'b0;
      rd_v1     <= 1'b0;
      rd_v2     <= 1'b0;
      last1     <= 1'b0;
      last2     <= 1'b0;
`ifdef FILTER_SPAD_CTRL_REPEAT_EN
      rep_q     <= '0;
      pass_cnt  <= '0;
      pl1       <= 1'b0;
      pl2       <= 1'b0;
`endif
    end else begin
      done <= ((start_ld || start_rd) && len_zero) || ((state == DRAIN) && drain_done);

      if ((start_ld || start_rd) && !len_zero) len_q <= len_clip;

      // A write is presented for exactly the cycle after each accepted word.
      spad_we <= ld_accept;
      if (ld_accept) begin
        spad_addr <= wcnt;
        wr_data   <= ld_data;
        wcnt      <= ld_last ? '0 : wcnt + ADDR_W'(1);
      end else if (issue) begin
        spad_addr <= issue_addr;
        rcnt      <= pass_end ? '0 : issue_addr + ADDR_W'(1);
      end

      rd_v1 <= issue;
      last1 <= issue_final;
      rd_v2 <= rd_v1;
      last2 <= last1;
`ifdef FILTER_SPAD_CTRL_REPEAT_EN
      if (start_rd) rep_q <= rd_repeat;
      if (pass_end) pass_cnt <= final_pass ? 8'd0 : pass_cnt + 8'd1;
      pl1 <= pass_end;
      pl2 <= pl1;
`endif
    end
  end

  // Bus drive: the write word only while a write is presented.
  assign spad_data = spad_we ? wr_data : {DATA_W{1'bz}};

  // ---------------------------------------------------------------------------
  // Skid buffer
  // ---------------------------------------------------------------------------
  assign push = rd_v2;
  assign pop  = out_valid && out_ready;

  always_comb begin
    push_entry      = '0;
    push_entry.data = spad_data;
    push_entry.last = last2;
`ifdef FILTER_SPAD_CTRL_REPEAT_EN
    push_entry.pass_last = pl2;
`endif
  end

  // Buffer storage, written on every captured read.
  // NOTE: storage is not reset; count and pointers alone define which entries
  // are live, and the outputs are gated to zero while the buffer is empty.
  always_ff @(posedge clk) begin
    if (push) buf_mem[tail] <= push_entry;
  end

  // Buffer pointers and occupancy; simultaneous push and pop both proceed.
  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      buf_count <= '0;
    end else begin
      if (push) tail <= ptr_inc(tail);
      if (pop)  head <= ptr_inc(head);
      case ({push, pop})
        2'b10:   buf_count <= buf_count + CNT_W'(1);
        2'b01:   buf_count <= buf_count - CNT_W'(1);
        default: buf_count <= buf_count;
      endcase
    end
  end

  assign head_entry = buf_mem[head];
  assign out_valid  = (buf_count != '0);
  assign out_data   = out_valid ? head_entry.data : '0;
  assign out_last   = out_valid && head_entry.last;
`ifdef FILTER_SPAD_CTRL_REPEAT_EN
  assign pass_last  = out_valid && head_entry.pass_last;
`endif

endmodule

// File: tb/tb_filter_spad_ctrl.sv
// tb_filter_spad_ctrl: directed self-checking bench for filter_spad_ctrl.
// Includes a behavioural 256x16 scratchpad with a one-cycle registered read
// that shares the tristate bus with the controller.

module tb_filter_spad_ctrl;

  logic        clk;
  logic        rst;
  logic [7:0]  cfg_len;
  logic        ld_start, ld_valid, ld_ready;
  logic [15:0] ld_data;
  logic        rd_start;
  logic        out_valid, out_ready, out_last;
  logic [15:0] out_data;
  logic        busy, done;
  logic [7:0]  spad_addr;
  logic        spad_we;
  wire  [15:0] spad_data;
`ifdef FILTER_SPAD_CTRL_REPEAT_EN
  logic [7:0]  rd_repeat;
  logic        pass_last;
`endif

  filter_spad_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_len   (cfg_len),
    .ld_start  (ld_start),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_data   (ld_data),
    .rd_start  (rd_start),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
`ifdef FILTER_SPAD_CTRL_REPEAT_EN
    .rd_repeat (rd_repeat),
    .pass_last (pass_last),
`endif
    .busy      (busy),
    .done      (done),
    .spad_addr (spad_addr),
    .spad_we   (spad_we),
    .spad_data (spad_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scratchpad model: registered read, drives the bus only in a non-write
  // cycle that follows a non-write cycle.
  logic [15:0] spad_mem [256];
  logic [15:0] spad_q;
  logic        spad_drv;
  int          wr_cnt = 0;

  always @(posedge clk) begin
    if (spad_we) begin
      spad_mem[spad_addr] <= spad_data;
      wr_cnt <= wr_cnt + 1;
    end
    spad_q   <= spad_mem[spad_addr];
    spad_drv <= !spad_we;
  end

  assign spad_data = (spad_drv && !spad_we) ? spad_q : 16'bz;

  // Expected scratchpad contents, built from the words the bench loads.
  logic [15:0] exp_mem [256];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs a load of len words starting at base; pat=1 inserts ld_valid gaps.
  task automatic run_load(input logic [7:0] len, input logic [15:0] base, input int pat,
                          input int expect_n);
    int acc, cyc, w0;
    logic got;
    cfg_len  = len;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    acc = 0; cyc = 0; got = 1'b0; w0 = wr_cnt;
    while (!got && cyc < 600) begin
      ld_valid = (pat == 0) || (cyc % 2 == 0);
      ld_data  = base + acc[15:0];
      if (done) got = 1'b1;
      else if (ld_valid && ld_ready) begin
        if (acc < 256) exp_mem[acc] = ld_data;
        acc++;
      end
      tick();
      cyc++;
    end
    ld_valid = 1'b0;
    check("ld_count", acc, expect_n);
    check("ld_writes", wr_cnt - w0, expect_n);
    check("ld_done_seen", got, 1);
  endtask

  // Runs a readout; pat=1 drives out_ready 1,0,0,1,0,0...
  task automatic run_read(input logic [7:0] len, input int reps, input int pat,
                          output int first_cyc, output int last_cyc, output int done_cyc,
                          output int max_out);
    int n, k, cyc, l, o, unstable;
    logic prev_stall;
    logic [15:0] prev_data;
    l = len;
    n = l * (reps + 1);
    cfg_len  = len;
`ifdef FILTER_SPAD_CTRL_REPEAT_EN
    rd_repeat = reps[7:0];
`endif
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    k = 0; cyc = 1; first_cyc = -1; last_cyc = -1; done_cyc = -1;
    max_out = 0; unstable = 0; prev_stall = 1'b0; prev_data = '0;
    while (done_cyc < 0 && cyc < 2000) begin
      out_ready = (pat == 0) || ((cyc - 1) % 3 == 0);
      if (done) done_cyc = cyc;
      if (prev_stall && (!out_valid || out_data != prev_data)) unstable++;
      if (reps == 0) begin
        o = int'(spad_addr) + 1 - k;
        if (o > max_out) max_out = o;
      end
      if (out_valid && out_ready) begin
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        check("rd_data", out_data, exp_mem[k % l]);
        check("rd_last", out_last, k == n - 1);
`ifdef FILTER_SPAD_CTRL_REPEAT_EN
        check("rd_pass_last", pass_last, (k % l) == l - 1);
`endif
        k++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    check("rd_count", k, n);
    check("rd_stable", unstable, 0);
    check("rd_done_seen", done_cyc >= 0, 1);
  endtask

  int f, l, d, mo, acc, vcnt, cyc;
  logic got;

  initial begin
    rst = 1'b1; cfg_len = '0; ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0;
    rd_start = 1'b0; out_ready = 1'b0;
`ifdef FILTER_SPAD_CTRL_REPEAT_EN
    rd_repeat = '0;
`endif
    for (int i = 0; i < 256; i++) exp_mem[i] = '0;

    // Reset state
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ld_ready", ld_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_spad_we", spad_we, 0);
    check("rst_spad_addr", spad_addr, 0);
    rst = 1'b0;
    tick();

    // Load three words with exact cycle timing
    cfg_len = 8'd3; ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    check("ld_ready_on", ld_ready, 1);
    check("ld_busy", busy, 1);
    ld_valid = 1'b1; ld_data = 16'h1111;
    tick();
    check("wr0_we", spad_we, 1);
    check("wr0_addr", spad_addr, 0);
    check("wr0_bus", spad_data, 16'h1111);
    ld_data = 16'h2222;
    tick();
    check("wr1_we", spad_we, 1);
    check("wr1_addr", spad_addr, 1);
    check("wr1_bus", spad_data, 16'h2222);
    ld_data = 16'h3333;
    tick();
    check("wr2_we", spad_we, 1);
    check("wr2_addr", spad_addr, 2);
    check("wr2_bus", spad_data, 16'h3333);
    check("ld_ready_off", ld_ready, 0);
    ld_valid = 1'b0;
    tick();
    check("we_fall", spad_we, 0);
    check("done_not_yet", done, 0);
    tick();
    check("ld_done", done, 1);
    check("ld_idle", busy, 0);
    tick();
    check("done_one_cycle", done, 0);
    exp_mem[0] = 16'h1111; exp_mem[1] = 16'h2222; exp_mem[2] = 16'h3333;

    // Read three words back at full rate
    run_read(8'd3, 0, 0, f, l, d, mo);
    check("rd3_first_cycle", f, 3);
    check("rd3_last_cycle", l, 5);
    check("rd3_done_cycle", d, 7);

    // Eight words with ld_valid gaps, read back under out_ready stalls
    run_load(8'd8, 16'hA000, 1, 8);
    run_read(8'd8, 0, 1, f, l, d, mo);
    check("rd8_outstanding_le_buf", mo <= 4, 1);

    // Zero-length read: done next cycle, no scratchpad access
    cfg_len = 8'd0; rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    check("len0_done", done, 1);
    check("len0_busy", busy, 0);
    check("len0_spad_we", spad_we, 0);
    check("len0_out_valid", out_valid, 0);
    tick();
    check("len0_done_cleared", done, 0);

    // Over-long load is clamped to the scratchpad depth
    run_load(8'd250, 16'hC000, 0, 224);

    // Simultaneous starts: load wins; a start during the load is ignored
    cfg_len = 8'd2; ld_start = 1'b1; rd_start = 1'b1;
    tick();
    ld_start = 1'b0; rd_start = 1'b0;
    check("both_ld_wins", ld_ready, 1);
    acc = 0; vcnt = 0; got = 1'b0; cyc = 0; ld_valid = 1'b1;
    while (!got && cyc < 50) begin
      rd_start = (cyc == 0);
      cfg_len  = (cyc == 0) ? 8'd5 : 8'd2;
      ld_data  = (acc == 0) ? 16'h5A5A : 16'hA5A5;
      if (out_valid) vcnt++;
      if (done) got = 1'b1;
      else if (ld_valid && ld_ready) begin
        exp_mem[acc] = ld_data;
        acc++;
      end
      tick();
      cyc++;
    end
    rd_start = 1'b0; ld_valid = 1'b0;
    check("both_ld_count", acc, 2);
    check("both_no_readout", vcnt, 0);
    check("both_done_seen", got, 1);
    tick();
    check("both_idle_after", busy, 0);
    check("both_no_valid_after", out_valid, 0);

    // Reset mid-read after two words, then restart from address 0
    cfg_len = 8'd6; rd_start = 1'b1;
    tick();
    rd_start = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    check("rst_rd_w0", out_data, exp_mem[0]);
    tick();
    check("rst_rd_w1", out_data, exp_mem[1]);
    tick();
    rst = 1'b1;
    tick();
    out_ready = 1'b0;
    check("abort_out_valid", out_valid, 0);
    check("abort_out_data", out_data, 0);
    check("abort_out_last", out_last, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_ld_ready", ld_ready, 0);
    check("abort_spad_we", spad_we, 0);
    check("abort_spad_addr", spad_addr, 0);
    rst = 1'b0;
    run_read(8'd3, 0, 0, f, l, d, mo);
    check("restart_first_cycle", f, 3);
    check("restart_last_cycle", l, 5);

`ifdef FILTER_SPAD_CTRL_REPEAT_EN
    // Two-word filter replayed three times back-to-back
    run_read(8'd2, 2, 0, f, l, d, mo);
    check("rep_first_cycle", f, 3);
    check("rep_last_cycle", l, 8);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
